// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: instruction decode stage with register file, write-through
// read bypass, load/RAW hazard detection, branch resolution and the ID/EXE
// pipeline register. Optional performance counters (stall_cnt, br_cnt) are
// built only when the macro ID_PERF_CNT_EN is defined.
module id_stage_pipelined #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 4,
   parameter int INSTR_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               flagZ,
   input  logic               forward_EN,
   input  logic               writeEn,
   input  logic [ADDR_W-1:0]  dest,
   input  logic [DATA_W-1:0]  writeVal,
   input  logic [ADDR_W-1:0]  dest_EXE,
   input  logic [ADDR_W-1:0]  dest_MEM,
   input  logic               WB_EN_EXE,
   input  logic               WB_EN_MEM,
   input  logic               MEM_R_EN_EXE,
   output logic               hazard_detected,
   output logic               brTaken,
   output logic               id_valid,
   output logic [ADDR_W-1:0]  src1,
   output logic [ADDR_W-1:0]  src2,
   output logic [ADDR_W-1:0]  dst_o,
   output logic [DATA_W-1:0]  val1,
   output logic [DATA_W-1:0]  val2,
   output logic [DATA_W-1:0]  st_val,
   output logic               is_imm,
   output logic               ST,
   output logic               MEM_R_EN,
   output logic               MEM_W_EN,
   output logic               WB_EN,
   output logic [3:0]         EXE_CMD
`ifdef ID_PERF_CNT_EN
   ,
   output logic [15:0]        stall_cnt,
   output logic [15:0]        br_cnt
`endif
);

   typedef enum logic [3:0] {
      OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
      OP_ADDI = 4'd5, OP_LD = 4'd6, OP_ST = 4'd7, OP_BEQZ = 4'd8, OP_B = 4'd9
   } op_e;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] src1;
      logic [ADDR_W-1:0] src2;
      logic [ADDR_W-1:0] dst;
      logic [DATA_W-1:0] val1;
      logic [DATA_W-1:0] val2;
      logic [DATA_W-1:0] st_val;
      logic              is_imm;
      logic              st;
      logic              mem_r;
      logic              mem_w;
      logic              wb;
      logic [3:0]        cmd;
   } idex_t;

   // Instruction fields; note s1 overlaps the upper nibble of imm8.
   logic [3:0]        op;
   logic [ADDR_W-1:0] f_dst, f_s1, f_s2;
   logic [7:0]        imm8;
   assign op    = instruction[INSTR_W-1 -: 4];
   assign f_dst = instruction[8 +: ADDR_W];
   assign f_s1  = instruction[4 +: ADDR_W];
   assign f_s2  = instruction[0 +: ADDR_W];
   assign imm8  = instruction[7:0];

   logic uses_s1, uses_s2, is_st, is_ld, imm_op, wb_op;
   assign uses_s1 = (op >= OP_ADD) && (op <= OP_ST);
   assign uses_s2 = (op >= OP_ADD) && (op <= OP_OR);
   assign is_st   = (op == OP_ST);
   assign is_ld   = (op == OP_LD);
   assign imm_op  = (op == OP_ADDI) || is_ld || is_st;
   assign wb_op   = (op >= OP_ADD) && (op <= OP_LD);

   // Register file with write-through bypass on every read port; R0 reads 0.
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rd_s1, rd_s2, rd_dst;
   assign rd_s1  = (f_s1 == '0)  ? '0 : (writeEn && dest == f_s1)  ? writeVal : regs[f_s1];
   assign rd_s2  = (f_s2 == '0)  ? '0 : (writeEn && dest == f_s2)  ? writeVal : regs[f_s2];
   assign rd_dst = (f_dst == '0) ? '0 : (writeEn && dest == f_dst) ? writeVal : regs[f_dst];

   // A producer address matches when it is nonzero and equals any used source.
   logic match_exe, match_mem, haz_raw;
   assign match_exe = (dest_EXE != '0) &&
                      ((uses_s1 && f_s1 == dest_EXE) || (uses_s2 && f_s2 == dest_EXE) ||
                       (is_st && f_dst == dest_EXE));
   assign match_mem = (dest_MEM != '0) &&
                      ((uses_s1 && f_s1 == dest_MEM) || (uses_s2 && f_s2 == dest_MEM) ||
                       (is_st && f_dst == dest_MEM));
   assign haz_raw = forward_EN ? (MEM_R_EN_EXE && WB_EN_EXE && match_exe)
                               : ((WB_EN_EXE && match_exe) || (WB_EN_MEM && match_mem));

   assign hazard_detected = instr_valid && haz_raw;
   assign brTaken = instr_valid && !hazard_detected &&
                    ((op == OP_B) || (op == OP_BEQZ && flagZ));

   // Decode the next ID/EXE contents; stalls and empty slots become all-zero bubbles.
   idex_t nxt;
   always_comb begin
      // NOTE: defaulting the whole struct first keeps every path assigned, so no latch is inferred.
      nxt = '0;
      if (instr_valid && !hazard_detected) begin
         nxt.valid = 1'b1;
         if (uses_s1) begin
            nxt.src1 = f_s1;
            nxt.val1 = rd_s1;
         end
         if (uses_s2) begin
            nxt.src2 = f_s2;
            nxt.val2 = rd_s2;
         end
         if (imm_op) nxt.val2 = {{(DATA_W-8){1'b0}}, imm8};
         if (is_st) nxt.st_val = rd_dst;
         if (wb_op || is_st) nxt.dst = f_dst;
         nxt.is_imm = imm_op;
         nxt.st     = is_st;
         nxt.mem_r  = is_ld;
         nxt.mem_w  = is_st;
         nxt.wb     = wb_op;
         case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_ST: nxt.cmd = 4'd1;
            OP_SUB:                        nxt.cmd = 4'd2;
            OP_AND:                        nxt.cmd = 4'd3;
            OP_OR:                         nxt.cmd = 4'd4;
            default:                       nxt.cmd = 4'd0;
         endcase
      end
   end

   // Register file write port; R0 is never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the register file must read zero after reset, so the array is cleared here rather than left to a RAM macro.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (writeEn && dest != '0) begin
         // NOTE: non-blocking assignment so every reader of regs sees the pre-edge value this cycle.
         regs[dest] <= writeVal;
      end
   end

   // ID/EXE pipeline register.
   idex_t slot;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) slot <= '0;
      else     slot <= nxt;
   end

   assign id_valid = slot.valid;
   assign src1     = slot.src1;
   assign src2     = slot.src2;
   assign dst_o    = slot.dst;
   assign val1     = slot.val1;
   assign val2     = slot.val2;
   assign st_val   = slot.st_val;
   assign is_imm   = slot.is_imm;
   assign ST       = slot.st;
   assign MEM_R_EN = slot.mem_r;
   assign MEM_W_EN = slot.mem_w;
   assign WB_EN    = slot.wb;
   assign EXE_CMD  = slot.cmd;

`ifdef ID_PERF_CNT_EN
   // Saturating stall and taken-branch counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         br_cnt    <= '0;
      end else begin
         if (hazard_detected && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
         if (brTaken && br_cnt != 16'hFFFF)            br_cnt    <= br_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: a table of single-cycle decode
// vectors plus hand-written reset, load-use and no-forwarding stall sequences.
// Registered expectations go through a queue and are compared after each edge.
module tb_id_stage_pipelined;

   localparam int OUT_W = 70;

   typedef struct packed {
      logic        vld;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [3:0]  d;
      logic [15:0] v1;
      logic [15:0] v2;
      logic [15:0] sv;
      logic [4:0]  ctl;   // {is_imm, ST, MEM_R_EN, MEM_W_EN, WB_EN}
      logic [3:0]  cmd;
   } out_t;

   typedef struct {
      logic [15:0] instr;
      logic        iv;
      logic        fz;
      logic        we;
      logic [3:0]  wd;
      logic [15:0] wv;
      logic [1:0]  hb;    // {hazard_detected, brTaken}
      out_t        exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic instr_valid = 1'b0;
   logic [15:0] instruction = '0;
   logic flagZ = 1'b0, forward_EN = 1'b1, writeEn = 1'b0;
   logic [3:0] dest = '0, dest_EXE = '0, dest_MEM = '0;
   logic [15:0] writeVal = '0;
   logic WB_EN_EXE = 1'b0, WB_EN_MEM = 1'b0, MEM_R_EN_EXE = 1'b0;
   logic hazard_detected, brTaken, id_valid;
   logic [3:0] src1, src2, dst_o, EXE_CMD;
   logic [15:0] val1, val2, st_val;
   logic is_imm, ST, MEM_R_EN, MEM_W_EN, WB_EN;
`ifdef ID_PERF_CNT_EN
   logic [15:0] stall_cnt, br_cnt;
`endif

   int checks = 0;
   int errors = 0;
   out_t exp_q[$];
   vec_t vecs[18];

   id_stage_pipelined dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
      .flagZ(flagZ), .forward_EN(forward_EN), .writeEn(writeEn), .dest(dest),
      .writeVal(writeVal), .dest_EXE(dest_EXE), .dest_MEM(dest_MEM),
      .WB_EN_EXE(WB_EN_EXE), .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_EXE(MEM_R_EN_EXE),
      .hazard_detected(hazard_detected), .brTaken(brTaken), .id_valid(id_valid),
      .src1(src1), .src2(src2), .dst_o(dst_o), .val1(val1), .val2(val2),
      .st_val(st_val), .is_imm(is_imm), .ST(ST), .MEM_R_EN(MEM_R_EN),
      .MEM_W_EN(MEM_W_EN), .WB_EN(WB_EN), .EXE_CMD(EXE_CMD)
`ifdef ID_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .br_cnt(br_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   function automatic out_t dut_out();
      out_t o;
      o.vld = id_valid; o.s1 = src1; o.s2 = src2; o.d = dst_o;
      o.v1 = val1; o.v2 = val2; o.sv = st_val;
      o.ctl = {is_imm, ST, MEM_R_EN, MEM_W_EN, WB_EN};
      o.cmd = EXE_CMD;
      return o;
   endfunction

   task automatic check_hb(input string name, input logic [1:0] exp);
      check(name, OUT_W'({hazard_detected, brTaken}), OUT_W'(exp));
   endtask

   // Push the expected ID/EXE contents, clock once, then pop and compare.
   task automatic step(input string name, input out_t e);
      out_t x;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard empty", name);
      end else begin
         x = exp_q.pop_front();
         check(name, dut_out(), x);
      end
   endtask

   task automatic preload();
      for (int n = 1; n < 16; n++) begin
         @(negedge clk);
         instr_valid = 1'b0; writeEn = 1'b1; dest = 4'(n); writeVal = 16'(n * 17);
         @(posedge clk);
      end
      @(negedge clk);
      writeEn = 1'b0;
   endtask

   initial begin
      // Registers preloaded to Rn = n*0x11. In ADDI/LD/ST the s1 field is imm8[7:4].
      vecs[0]  = '{16'h1123, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h2, 4'h3, 4'h1, 16'h0022, 16'h0033, 16'h0, 5'b00001, 4'h1}};
      vecs[1]  = '{16'h2456, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h5, 4'h6, 4'h4, 16'h0055, 16'h0066, 16'h0, 5'b00001, 4'h2}};
      vecs[2]  = '{16'h3789, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h8, 4'h9, 4'h7, 16'h0088, 16'h0099, 16'h0, 5'b00001, 4'h3}};
      vecs[3]  = '{16'h4ABC, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'hB, 4'hC, 4'hA, 16'h00BB, 16'h00CC, 16'h0, 5'b00001, 4'h4}};
      vecs[4]  = '{16'h51F0, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'hF, 4'h0, 4'h1, 16'h00FF, 16'h00F0, 16'h0, 5'b10001, 4'h1}};
      vecs[5]  = '{16'h6235, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h3, 4'h0, 4'h2, 16'h0033, 16'h0035, 16'h0, 5'b10101, 4'h1}};
      vecs[6]  = '{16'h7402, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h0, 4'h0, 4'h4, 16'h0000, 16'h0002, 16'h0044, 5'b11010, 4'h1}};
      vecs[7]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 5'b00000, 4'h0}};
      vecs[8]  = '{16'hC123, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 5'b00000, 4'h0}};
      vecs[9]  = '{16'h8000, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0,    2'b01, '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 5'b00000, 4'h0}};
      vecs[10] = '{16'h8000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 5'b00000, 4'h0}};
      vecs[11] = '{16'h9000, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b01, '{1'b1, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 5'b00000, 4'h0}};
      vecs[12] = '{16'h1123, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b0, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 5'b00000, 4'h0}};
      vecs[13] = '{16'h9000, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b0, 4'h0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 5'b00000, 4'h0}};
      vecs[14] = '{16'h1130, 1'b1, 1'b0, 1'b1, 4'h3, 16'h00AA, 2'b00, '{1'b1, 4'h3, 4'h0, 4'h1, 16'h00AA, 16'h0, 16'h0, 5'b00001, 4'h1}};
      vecs[15] = '{16'h2233, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h3, 4'h3, 4'h2, 16'h00AA, 16'h00AA, 16'h0, 5'b00001, 4'h2}};
      vecs[16] = '{16'h1100, 1'b1, 1'b0, 1'b1, 4'h0, 16'hBEEF, 2'b00, '{1'b1, 4'h0, 4'h0, 4'h1, 16'h0, 16'h0, 16'h0, 5'b00001, 4'h1}};
      vecs[17] = '{16'h4100, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0,    2'b00, '{1'b1, 4'h0, 4'h0, 4'h1, 16'h0, 16'h0, 16'h0, 5'b00001, 4'h4}};

      // Power-on reset
      #12;
      check("reset_outputs", OUT_W'(dut_out()), OUT_W'(0));
      check_hb("reset_hb", 2'b00);
      @(negedge clk);
      rst = 1'b0;
      preload();

      // Table-driven decode vectors, forwarding present, pipeline idle
      forward_EN = 1'b1;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         instruction = vecs[i].instr; instr_valid = vecs[i].iv; flagZ = vecs[i].fz;
         writeEn = vecs[i].we; dest = vecs[i].wd; writeVal = vecs[i].wv;
         #1;
         check_hb($sformatf("vec%0d_hb", i), vecs[i].hb);
         step($sformatf("vec%0d_out", i), vecs[i].exp);
      end
`ifdef ID_PERF_CNT_EN
      check("br_cnt", OUT_W'(br_cnt), OUT_W'(16'd2));
      check("stall_cnt_zero", OUT_W'(stall_cnt), OUT_W'(16'd0));
`endif

      // Mid-stream reset: slot currently holds an OR, must clear asynchronously
      @(negedge clk);
      instr_valid = 1'b0; writeEn = 1'b0; flagZ = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("midreset_outputs", OUT_W'(dut_out()), OUT_W'(0));
`ifdef ID_PERF_CNT_EN
      check("midreset_br_cnt", OUT_W'(br_cnt), OUT_W'(16'd0));
`endif
      @(negedge clk);
      rst = 1'b0;
      instruction = 16'h1123; instr_valid = 1'b1;
      step("regfile_cleared", '{1'b1, 4'h2, 4'h3, 4'h1, 16'h0, 16'h0, 16'h0, 5'b00001, 4'h1});
      preload();

      // Load-use hazard with forwarding: one bubble, then SUB R4,R2,R5 issues
      @(negedge clk);
      forward_EN = 1'b1; instruction = 16'h2425; instr_valid = 1'b1;
      dest_EXE = 4'h2; WB_EN_EXE = 1'b1; MEM_R_EN_EXE = 1'b0;
      #1 check_hb("fwd_alu_no_stall", 2'b00);
      #1 MEM_R_EN_EXE = 1'b1;
      #1 check_hb("load_use_hazard", 2'b10);
      step("load_use_bubble", '0);
      @(negedge clk);
      MEM_R_EN_EXE = 1'b0; WB_EN_EXE = 1'b0; dest_EXE = 4'h0;
      #1 check_hb("load_use_clear", 2'b00);
      step("load_use_issue", '{1'b1, 4'h2, 4'h5, 4'h4, 16'h0022, 16'h0055, 16'h0, 5'b00001, 4'h2});
`ifdef ID_PERF_CNT_EN
      check("stall_cnt_one", OUT_W'(stall_cnt), OUT_W'(16'd1));
`endif

      // No forwarding: MEM writes R5, AND R6,R5,R7 stalls two cycles; WB of R5 lands during the stall
      @(negedge clk);
      forward_EN = 1'b0; instruction = 16'h3657; WB_EN_MEM = 1'b1; dest_MEM = 4'h5;
      #1 check_hb("nofwd_mem_hazard1", 2'b10);
      step("nofwd_bubble1", '0);
      @(negedge clk);
      writeEn = 1'b1; dest = 4'h5; writeVal = 16'h1234;
      #1 check_hb("nofwd_mem_hazard2", 2'b10);
      step("nofwd_bubble2", '0);
      @(negedge clk);
      writeEn = 1'b0; WB_EN_MEM = 1'b0; dest_MEM = 4'h0;
      #1 check_hb("nofwd_mem_clear", 2'b00);
      step("nofwd_issue", '{1'b1, 4'h5, 4'h7, 4'h6, 16'h1234, 16'h0077, 16'h0, 5'b00001, 4'h3});

      // No forwarding: EXE match on s2 stalls; a producer of R0 never does
      @(negedge clk);
      WB_EN_EXE = 1'b1; dest_EXE = 4'h7;
      #1 check_hb("nofwd_exe_s2_hazard", 2'b10);
      WB_EN_EXE = 1'b0; dest_EXE = 4'h0;
      instruction = 16'h3607; WB_EN_MEM = 1'b1; dest_MEM = 4'h0;
      #1 check_hb("r0_no_hazard", 2'b00);
      step("r0_src_issue", '{1'b1, 4'h0, 4'h7, 4'h6, 16'h0, 16'h0077, 16'h0, 5'b00001, 4'h3});

      // Store data register (dst field) is a used source
      @(negedge clk);
      WB_EN_MEM = 1'b0; instruction = 16'h7402; WB_EN_EXE = 1'b1; dest_EXE = 4'h4;
      #1 check_hb("st_data_hazard", 2'b10);
      instr_valid = 1'b0;
      #1 check_hb("hazard_gated_by_valid", 2'b00);
      WB_EN_EXE = 1'b0; dest_EXE = 4'h0;
      step("idle_after", '0);
`ifdef ID_PERF_CNT_EN
      check("stall_cnt_final", OUT_W'(stall_cnt), OUT_W'(16'd3));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
